// File: rtl/ce_frame_tx.sv
// ============================================================================
//  Module   : ce_frame_tx
//  Purpose  : Framing transmitter. Turns an unframed valid/ready sample stream
//             into Avalon-ST frames of fftpts_in beats (sop/eop marked). It has
//             a 2-entry skid FIFO, a registered output stage and an enforced
//             idle gap of GAP_CYCLES cycles after every eop transfer.
//  Options  : CE_FRAME_TX_LENCHK_EN - when defined, a frame may only start
//             when fftpts_in is a power of two in 8..2048.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ce_frame_tx #(
  parameter int wData      = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [wData-1:0] in_real,
  input  logic [wData-1:0] in_imag,
  input  logic [11:0]      fftpts_in,
  output logic             source_valid,
  input  logic             source_ready,
  output logic [1:0]       source_error,
  output logic             source_sop,
  output logic             source_eop,
  output logic [wData-1:0] source_real,
  output logic [wData-1:0] source_imag,
  output logic [11:0]      fftpts_out
);

  localparam int         ENTRY_W  = 2 + 12 + 2 * wData;
  // The gap counter is preloaded with GAP_CYCLES-1 and the load happens on
  // the edge that sees it at zero, giving exactly GAP_CYCLES idle cycles.
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------- tagger
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] len_q, len_d;
  logic [11:0] eff_len;
  logic        length_ok;
  logic        accept;
  logic        tag_sop;
  logic        tag_eop;

  // ------------------------------------------------------------------ fifo
  logic [1:0][ENTRY_W-1:0] mem_q, mem_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ENTRY_W-1:0]      wr_entry;
  logic [ENTRY_W-1:0]      rd_entry;
  logic                    e_sop;
  logic                    e_eop;
  logic [11:0]             e_len;
  logic [wData-1:0]        e_real;
  logic [wData-1:0]        e_imag;

  // -------------------------------------------------------- output stage
  state_t           state_q, state_d;
  logic [7:0]       gap_q, gap_d;
  logic             load;
  logic             slot_free;
  logic             eop_xfer;
  logic             out_valid_q, out_valid_d;
  logic             out_sop_q, out_sop_d;
  logic             out_eop_q, out_eop_d;
  logic [wData-1:0] out_real_q, out_real_d;
  logic [wData-1:0] out_imag_q, out_imag_d;
  logic [11:0]      fftpts_out_q, fftpts_out_d;

`ifdef CE_FRAME_TX_LENCHK_EN
  logic len_legal;

  // Legal frame lengths: powers of two from 8 to 2048.
  always_comb begin
    len_legal = 1'b0;
    case (fftpts_in)
      12'd8, 12'd16, 12'd32, 12'd64, 12'd128,
      12'd256, 12'd512, 12'd1024, 12'd2048: len_legal = 1'b1;
      default: len_legal = 1'b0;
    endcase
  end

  // Only the start of a frame is gated; mid-frame values are never looked at.
  assign length_ok = (cnt_q != 12'd0) || len_legal;
`else
  assign length_ok = 1'b1;
`endif

  assign fifo_full  = (count_q == 2'd2);
  assign fifo_empty = (count_q == 2'd0);
  assign in_ready   = !fifo_full && length_ok && !rst;
  assign accept     = in_valid && in_ready;

  // The length used for tagging is the live input on the sop beat and the
  // latched value afterwards. A length of 0 wraps to 4095 for the eop
  // compare, which makes it behave as a 4096-beat frame.
  assign eff_len = (cnt_q == 12'd0) ? fftpts_in : len_q;
  assign tag_sop = (cnt_q == 12'd0);
  assign tag_eop = (cnt_q == (eff_len - 12'd1));

  // Beat counter and latched frame length.
  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    if (accept) begin
      if (tag_sop) len_d = fftpts_in;
      cnt_d = tag_eop ? 12'd0 : (cnt_q + 12'd1);
    end
  end

  assign wr_entry = {tag_sop, tag_eop, eff_len, in_real, in_imag};
  assign rd_entry = mem_q[rd_ptr_q];
  assign e_sop    = rd_entry[ENTRY_W-1];
  assign e_eop    = rd_entry[ENTRY_W-2];
  assign e_len    = rd_entry[ENTRY_W-3 -: 12];
  assign e_real   = rd_entry[2*wData-1 -: wData];
  assign e_imag   = rd_entry[wData-1:0];

  // Skid FIFO pointers, storage and occupancy; push and pop may coincide.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (load) rd_ptr_d = ~rd_ptr_q;
    case ({accept, load})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  assign slot_free = !out_valid_q || source_ready;
  assign eop_xfer  = out_valid_q && source_ready && out_eop_q;

  // Output FSM: decides when the output register pops the FIFO or idles.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    load         = 1'b0;
    out_valid_d  = out_valid_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_real_d   = out_real_q;
    out_imag_d   = out_imag_q;
    fftpts_out_d = fftpts_out_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (slot_free) begin
          if (eop_xfer && (GAP_CYCLES > 0)) begin
            out_valid_d = 1'b0;
            gap_d       = GAP_LOAD;
            state_d     = ST_GAP;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          if (!fifo_empty) begin
            load    = 1'b1;
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_sop_d   = e_sop;
      out_eop_d   = e_eop;
      out_real_d  = e_real;
      out_imag_d  = e_imag;
      if (e_sop) fftpts_out_d = e_len;
    end
  end

  // State registers; reset aborts any partial frame and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= 12'd0;
      len_q        <= 12'd0;
      mem_q        <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      state_q      <= ST_IDLE;
      gap_q        <= 8'd0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_real_q   <= '0;
      out_imag_q   <= '0;
      fftpts_out_q <= 12'd0;
    end else begin
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      gap_q        <= gap_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_real_q   <= out_real_d;
      out_imag_q   <= out_imag_d;
      fftpts_out_q <= fftpts_out_d;
    end
  end

  assign source_valid = out_valid_q;
  assign source_sop   = out_sop_q;
  assign source_eop   = out_eop_q;
  assign source_real  = out_real_q;
  assign source_imag  = out_imag_q;
  assign source_error = 2'b00;
  assign fftpts_out   = fftpts_out_q;

endmodule

`default_nettype wire
